// File: rtl/vedic_mul8_seq_pkg.sv
// Shared definitions for the sequential 8x8 vedic multiplier: FSM encoding,
// step count and the per-step accumulate shift table.
package vedic_mul8_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int VEDIC_STEPS = 4;
    localparam int STEP_W      = 2;

    // Shift applied to the nibble product of each step: lo*lo, hi*lo, lo*hi, hi*hi.
    function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
        logic [3:0] sh;
        case (step)
            2'd0:    sh = 4'd0;
            2'd1:    sh = 4'd4;
            2'd2:    sh = 4'd4;
            default: sh = 4'd8;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/vedic_mul8_seq_4x4.sv
// Combinational 4x4 unsigned vedic (urdhva-tiryagbhyam) multiplier built from
// four 2x2 vedic cells combined with shifted adds.
module vedic_4x4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    // 2x2 vedic cell: vertical and crosswise partial products.
    function automatic logic [3:0] v2x2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] s1;
        logic [1:0] s2;
        s1 = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
        s2 = {1'b0, a[1] & b[1]} + {1'b0, s1[1]};
        return {s2, s1[0], a[0] & b[0]};
    endfunction

    logic [3:0] q_ll, q_hl, q_lh, q_hh;

    // Four 2x2 products of the operand halves, summed with their weights.
    always_comb begin
        q_ll = v2x2(a_i[1:0], b_i[1:0]);
        q_hl = v2x2(a_i[3:2], b_i[1:0]);
        q_lh = v2x2(a_i[1:0], b_i[3:2]);
        q_hh = v2x2(a_i[3:2], b_i[3:2]);
        p_o  = {4'h0, q_ll}
             + ({4'h0, q_hl} << 2)
             + ({4'h0, q_lh} << 2)
             + ({4'h0, q_hh} << 4);
    end

endmodule

// File: rtl/vedic_mul8_seq.sv
// Sequential 8x8 unsigned multiplier: one shared vedic_4x4 evaluates the four
// nibble products over four cycles, accumulating them with shifts.
module vedic_mul8_seq
    import vedic_mul8_seq_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [7:0]  io_in_a,
    input  logic [7:0]  io_in_b,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [15:0] io_out_c,
    output logic        io_busy
);

    state_e            state_q;
    logic [STEP_W-1:0] step_q;
    logic [15:0]       acc_q;
    logic [7:0]        a_q, b_q;

    logic              accept;
    logic              zero_skip;
    logic [3:0]        nib_a, nib_b;
    logic [7:0]        prod;
    logic [15:0]       addend;

    // Handshake and status decode; in DONE a new request can only be taken
    // together with the output, which gives bubble-free back-to-back operation.
    always_comb begin
        io_in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && io_out_ready);
        io_out_valid = (state_q == ST_DONE);
        io_busy      = (state_q == ST_MUL);
        io_out_c     = acc_q;
        accept       = io_in_valid && io_in_ready;
        zero_skip    = SKIP_ZERO && ((a_q == 8'h00) || (b_q == 8'h00));
    end

    // Nibble select: step bit 0 picks the a half, step bit 1 picks the b half.
    always_comb begin
        nib_a  = step_q[0] ? a_q[7:4] : a_q[3:0];
        nib_b  = step_q[1] ? b_q[7:4] : b_q[3:0];
        addend = {8'h00, prod} << step_shift(step_q);
    end

    vedic_4x4 u_mul (
        .a_i (nib_a),
        .b_i (nib_b),
        .p_o (prod)
    );

    // FSM, operand latch and accumulator. A zero operand spends a single MUL
    // cycle (acc already 0) so the result appears one edge after the accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q     <= io_in_a;
                        b_q     <= io_in_b;
                        acc_q   <= '0;
                        step_q  <= '0;
                        state_q <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (zero_skip) begin
                        state_q <= ST_DONE;
                    end else begin
                        acc_q  <= acc_q + addend;
                        step_q <= step_q + 1'b1;
                        if (step_q == STEP_W'(VEDIC_STEPS - 1))
                            state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (io_out_ready) begin
                        if (accept) begin
                            a_q     <= io_in_a;
                            b_q     <= io_in_b;
                            acc_q   <= '0;
                            step_q  <= '0;
                            state_q <= ST_MUL;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
